// File: rtl/piano_voice_mixer.sv
// Mixes eight square-wave piano voices into one signed level and renders it as a
// 256-clock PWM stream; the level is resampled only at period boundaries.
`timescale 1ns/1ps

module piano_voice_mixer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] speaker,
    input  logic [7:0] en,
    output logic       pwm_out,
    output logic [4:0] level,
    output logic       sample_strobe,
    output logic       active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LEVEL_MID = 5'd8;
    localparam logic [7:0] CNT_LAST  = 8'hFF;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] duty_q, duty_nxt;
    logic [4:0] level_q, level_nxt;
    logic       pwm_nxt;
    logic       strobe_nxt;

    logic [3:0] n_up, n_dn;
    logic [4:0] mix_level;
    logic [8:0] duty_wide;
    logic [7:0] mix_duty;
    logic       any_en;

    assign any_en = |en;

    // Enabled voices vote +1 when high, -1 when low; offset by 8 so the level is unsigned.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        n_up = 4'd0;
        n_dn = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (en[i] && speaker[i]) begin
                n_up = n_up + 4'd1;
            end else if (en[i]) begin
                n_dn = n_dn + 4'd1;
            end
        end
        mix_level = LEVEL_MID + {1'b0, n_up} - {1'b0, n_dn};
    end

    // Full scale (16 * 16 = 256) does not fit the 8-bit compare, so it saturates.
    assign duty_wide = {mix_level, 4'b0000};
    assign mix_duty  = duty_wide[8] ? 8'hFF : duty_wide[7:0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        duty_nxt   = duty_q;
        level_nxt  = level_q;
        pwm_nxt    = 1'b0;
        strobe_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt  = 8'd0;
                duty_nxt = 8'd0;
                if (any_en) begin
                    state_nxt  = RUN;
                    duty_nxt   = mix_duty;
                    level_nxt  = mix_level;
                    strobe_nxt = 1'b1;
                end
            end

            RUN: begin
                cnt_nxt = cnt + 8'd1;
                pwm_nxt = (cnt < duty_q);
                // Inputs matter only at the wrap; mid-period changes are ignored.
                if (cnt == CNT_LAST) begin
                    if (any_en) begin
                        duty_nxt   = mix_duty;
                        level_nxt  = mix_level;
                        strobe_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        duty_nxt  = 8'd0;
                        level_nxt = LEVEL_MID;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            duty_q        <= 8'd0;
            level_q       <= LEVEL_MID;
            pwm_out       <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            duty_q        <= duty_nxt;
            level_q       <= level_nxt;
            pwm_out       <= pwm_nxt;
            sample_strobe <= strobe_nxt;
        end
    end

    assign level  = level_q;
    assign active = (state == RUN);

endmodule
